frontend_ex_pipe: RTL and testbench

FRONTEND_EX_PIPE -- requirements
Module: frontend_ex_pipe

---
 rtl/fe_pipe_pkg.sv | 35 +++
 rtl/fe_alu.sv | 35 +++
 rtl/frontend_ex_pipe.sv | 129 ++++++++++++
 tb/tb_frontend_ex_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fe_pipe_pkg.sv
// Shared types and ALU opcode encodings for the fetch/decode/execute front end.
package fe_pipe_pkg;

    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluSll  = 2;
    localparam int unsigned AluSlt  = 3;
    localparam int unsigned AluSltu = 4;
    localparam int unsigned AluXor  = 5;
    localparam int unsigned AluSrl  = 6;
    localparam int unsigned AluSra  = 7;
    localparam int unsigned AluOr   = 8;
    localparam int unsigned AluAnd  = 9;

    // Execute-stage controls; stype is the MSB.
    typedef struct packed {
        logic stype;
        logic utype;
        logic jtype;
        logic imm_alu;
        logic auipc;
        logic branch_alu;
        logic zeroflag_inv;
        logic alu_mdu;
    } ex_ctrl_t;

    // Controls carried through to later stages untouched.
    typedef struct packed {
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic       write_en;
        logic       branch_pc;
    } wb_ctrl_t;

endpackage

// File: rtl/fe_alu.sv
// Combinational integer ALU; unassigned opcodes return zero.
module fe_alu
    import fe_pipe_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned ALU_OP_WIDTH = 4
) (
    input  logic [WORD_WIDTH-1:0]   operand_a,
    input  logic [WORD_WIDTH-1:0]   operand_b,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [WORD_WIDTH-1:0]   result
);

    logic [4:0] shamt;
    assign shamt = operand_b[4:0];

    // Opcode decode; arithmetic wraps naturally at WORD_WIDTH.
    always_comb begin
        result = '0;
        case (32'(alu_op))
            AluAdd:  result = operand_a + operand_b;
            AluSub:  result = operand_a - operand_b;
            AluSll:  result = operand_a << shamt;
            AluSlt:  result = WORD_WIDTH'($signed(operand_a) < $signed(operand_b));
            AluSltu: result = WORD_WIDTH'(operand_a < operand_b);
            AluXor:  result = operand_a ^ operand_b;
            AluSrl:  result = operand_a >> shamt;
            AluSra:  result = $unsigned($signed(operand_a) >>> shamt);
            AluOr:   result = operand_a | operand_b;
            AluAnd:  result = operand_a & operand_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/frontend_ex_pipe.sv
// IF/ID and ID/EX pipeline registers around an external decoder, plus the execute stage.
module frontend_ex_pipe
    import fe_pipe_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_ctrl,
    input  logic [WORD_WIDTH-1:0]   program_count_i,
    input  logic [WORD_WIDTH-1:0]   pc_plus4_i,
    input  logic [WORD_WIDTH-1:0]   instruction_i,
    input  logic                    no_op_flag_i,
    output logic [WORD_WIDTH-1:0]   id_pc_o,
    output logic [WORD_WIDTH-1:0]   id_pc_plus4_o,
    output logic [WORD_WIDTH-1:0]   id_instruction_o,
    output logic                    id_no_op_flag_o,
    input  logic [WORD_WIDTH-1:0]   rdata1_i,
    input  logic [WORD_WIDTH-1:0]   rdata2_i,
    input  logic [ALU_OP_WIDTH-1:0] alu_op_ctrl_i,
    input  ex_ctrl_t                ex_ctrl_i,
    input  wb_ctrl_t                wb_ctrl_i,
    output logic [WORD_WIDTH-1:0]   ex_data_o,
    output logic                    branch_comp_flag_o,
    output logic [WORD_WIDTH-1:0]   store_data_o,
    output wb_ctrl_t                wb_ctrl_o
);

    logic [WORD_WIDTH-1:0]   if_pc_q, if_pc4_q, if_instr_q;
    logic                    if_nop_q;
    logic [WORD_WIDTH-1:0]   ex_pc_q, ex_pc4_q, ex_instr_q, ex_rs1_q, ex_rs2_q;
    logic [ALU_OP_WIDTH-1:0] ex_op_q;
    ex_ctrl_t                ex_ctrl_q;
    wb_ctrl_t                wb_q;

    // IF/ID: reset forces a bubble; stall holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_instr_q <= '0;
            if_nop_q   <= 1'b1;
        end else if (!stall_ctrl) begin
            if_pc_q    <= program_count_i;
            if_pc4_q   <= pc_plus4_i;
            if_instr_q <= instruction_i;
            if_nop_q   <= no_op_flag_i;
        end
    end

    assign id_pc_o          = if_pc_q;
    assign id_pc_plus4_o    = if_pc4_q;
    assign id_instruction_o = if_instr_q;
    assign id_no_op_flag_o  = if_nop_q;

    // ID/EX: a bubble in IF/ID loads an all-zero ADD; stall outranks the bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || (!stall_ctrl && if_nop_q)) begin
            ex_pc_q    <= '0;
            ex_pc4_q   <= '0;
            ex_instr_q <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_op_q    <= ALU_OP_WIDTH'(AluAdd);
            ex_ctrl_q  <= '0;
            wb_q       <= '0;
        end else if (!stall_ctrl) begin
            ex_pc_q    <= if_pc_q;
            ex_pc4_q   <= if_pc4_q;
            ex_instr_q <= if_instr_q;
            ex_rs1_q   <= rdata1_i;
            ex_rs2_q   <= rdata2_i;
            ex_op_q    <= alu_op_ctrl_i;
            ex_ctrl_q  <= ex_ctrl_i;
            wb_q       <= wb_ctrl_i;
        end
    end

    logic [WORD_WIDTH-1:0] imm, opa, opb, alu_result;
    logic                  unused_opcode;
    assign unused_opcode = ^ex_instr_q[6:0];

    // Immediate and operand selection.
    always_comb begin
        if (ex_ctrl_q.stype) begin
            imm = {{(WORD_WIDTH-12){ex_instr_q[31]}}, ex_instr_q[31:25], ex_instr_q[11:7]};
        end else if (ex_ctrl_q.utype) begin
            imm = WORD_WIDTH'({ex_instr_q[31:12], 12'b0});
        end else begin
            imm = {{(WORD_WIDTH-12){ex_instr_q[31]}}, ex_instr_q[31:20]};
        end
        if (ex_ctrl_q.auipc) begin
            opa = ex_pc_q;
        end else if (ex_ctrl_q.utype) begin
            opa = '0;
        end else begin
            opa = ex_rs1_q;
        end
        opb = ex_ctrl_q.imm_alu ? imm : ex_rs2_q;
    end

    fe_alu #(
        .WORD_WIDTH  (WORD_WIDTH),
        .ALU_OP_WIDTH(ALU_OP_WIDTH)
    ) u_alu (
        .operand_a(opa),
        .operand_b(opb),
        .alu_op   (ex_op_q),
        .result   (alu_result)
    );

    // Result select; the MDU path is reserved and reads as zero.
    always_comb begin
        if (ex_ctrl_q.jtype) begin
            ex_data_o = ex_pc4_q;
        end else if (ex_ctrl_q.alu_mdu) begin
            ex_data_o = '0;
        end else begin
            ex_data_o = alu_result;
        end
        branch_comp_flag_o = ex_ctrl_q.branch_alu &
                             ((alu_result == '0) ^ ex_ctrl_q.zeroflag_inv);
    end

    assign store_data_o = ex_rs2_q;
    assign wb_ctrl_o    = wb_q;

endmodule

// File: tb/tb_frontend_ex_pipe.sv
// Directed bench for frontend_ex_pipe with hand-computed expectations.
module tb_frontend_ex_pipe;
    import fe_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall_ctrl, no_op_flag_i;
    logic [31:0] program_count_i, pc_plus4_i, instruction_i;
    logic [31:0] id_pc_o, id_pc_plus4_o, id_instruction_o;
    logic        id_no_op_flag_o;
    logic [31:0] rdata1_i, rdata2_i;
    logic [3:0]  alu_op_ctrl_i;
    ex_ctrl_t    ex_ctrl_i;
    wb_ctrl_t    wb_ctrl_i;
    logic [31:0] ex_data_o, store_data_o;
    logic        branch_comp_flag_o;
    wb_ctrl_t    wb_ctrl_o;

    int vectors = 0;
    int miscompares = 0;

    frontend_ex_pipe dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_ctrl        (stall_ctrl),
        .program_count_i   (program_count_i),
        .pc_plus4_i        (pc_plus4_i),
        .instruction_i     (instruction_i),
        .no_op_flag_i      (no_op_flag_i),
        .id_pc_o           (id_pc_o),
        .id_pc_plus4_o     (id_pc_plus4_o),
        .id_instruction_o  (id_instruction_o),
        .id_no_op_flag_o   (id_no_op_flag_o),
        .rdata1_i          (rdata1_i),
        .rdata2_i          (rdata2_i),
        .alu_op_ctrl_i     (alu_op_ctrl_i),
        .ex_ctrl_i         (ex_ctrl_i),
        .wb_ctrl_i         (wb_ctrl_i),
        .ex_data_o         (ex_data_o),
        .branch_comp_flag_o(branch_comp_flag_o),
        .store_data_o      (store_data_o),
        .wb_ctrl_o         (wb_ctrl_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch an instruction, then present its decode one edge later; result is live after return.
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic [3:0] op,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input ex_ctrl_t ex, input wb_ctrl_t wb);
        program_count_i = pc;
        pc_plus4_i      = pc + 32'd4;
        instruction_i   = instr;
        no_op_flag_i    = 1'b0;
        tick();
        rdata1_i      = r1;
        rdata2_i      = r2;
        alu_op_ctrl_i = op;
        ex_ctrl_i     = ex;
        wb_ctrl_i     = wb;
        tick();
    endtask

    initial begin
        ex_ctrl_t ex;
        wb_ctrl_t wb;
        rst_n = 1'b0; stall_ctrl = 1'b0; no_op_flag_i = 1'b0;
        program_count_i = 32'h40; pc_plus4_i = 32'h44; instruction_i = 32'h1234_5678;
        rdata1_i = 32'h11; rdata2_i = 32'h22; alu_op_ctrl_i = 4'd1;
        ex_ctrl_i = '1; wb_ctrl_i = '1;
        tick();
        tick();
        check("rst_ex_data", ex_data_o, 32'h0);
        check("rst_flag", 32'(branch_comp_flag_o), 32'h0);
        check("rst_store", store_data_o, 32'h0);
        check("rst_wb", 32'(wb_ctrl_o), 32'h0);
        check("rst_id_nop", 32'(id_no_op_flag_o), 32'h1);
        check("rst_id_instr", id_instruction_o, 32'h0);
        rst_n = 1'b1;

        // ADD with the IF/ID stage observed after the first edge
        wb = '0; wb.write_en = 1'b1;
        ex = '0;
        program_count_i = 32'h100; pc_plus4_i = 32'h104;
        instruction_i = 32'h0020_81B3; no_op_flag_i = 1'b0;
        tick();
        check("id_pc", id_pc_o, 32'h100);
        check("id_pc4", id_pc_plus4_o, 32'h104);
        check("id_instr", id_instruction_o, 32'h0020_81B3);
        check("id_nop", 32'(id_no_op_flag_o), 32'h0);
        rdata1_i = 32'd5; rdata2_i = 32'd7; alu_op_ctrl_i = 4'd0; ex_ctrl_i = ex; wb_ctrl_i = wb;
        tick();
        check("add", ex_data_o, 32'd12);
        check("add_store", store_data_o, 32'd7);
        check("add_wb", 32'(wb_ctrl_o), 32'h02);

        issue(32'h104, 32'h4020_81B3, 4'd1, 32'd5, 32'd7, ex, wb);
        check("sub", ex_data_o, 32'hFFFF_FFFE);

        // Immediate forms
        ex = '0; ex.imm_alu = 1'b1;
        issue(32'h108, 32'h0400_0093, 4'd0, 32'd10, 32'h55, ex, wb);
        check("addi", ex_data_o, 32'd74);
        issue(32'h10C, 32'h7850_7093, 4'd9, 32'hFFFF_FFFF, 32'h0, ex, wb);
        check("andi", ex_data_o, 32'h0000_0785);
        issue(32'h110, 32'hFFF0_0093, 4'd0, 32'd10, 32'h0, ex, wb);
        check("addi_neg", ex_data_o, 32'd9);
        ex.stype = 1'b1;
        issue(32'h114, 32'hFE00_0F23, 4'd0, 32'h1000, 32'hABCD, ex, wb);
        check("store_addr", ex_data_o, 32'h0000_0FFE);
        check("store_data", store_data_o, 32'h0000_ABCD);
        ex = '0; ex.imm_alu = 1'b1; ex.utype = 1'b1;
        issue(32'h118, 32'h1234_5037, 4'd0, 32'hDEAD, 32'h0, ex, wb);
        check("lui", ex_data_o, 32'h1234_5000);
        ex.auipc = 1'b1;
        issue(32'h200, 32'h0000_1017, 4'd0, 32'hDEAD, 32'h0, ex, wb);
        check("auipc", ex_data_o, 32'h0000_1200);
        ex = '0; ex.jtype = 1'b1;
        issue(32'h300, 32'h0000_006F, 4'd0, 32'd1, 32'd2, ex, wb);
        check("jal", ex_data_o, 32'h304);
        ex = '0; ex.alu_mdu = 1'b1;
        issue(32'h308, 32'h0220_81B3, 4'd0, 32'd5, 32'd7, ex, wb);
        check("mdu", ex_data_o, 32'h0);

        // Remaining ALU operations
        ex = '0;
        issue(32'h30C, 32'h0, 4'd2, 32'd1, 32'h21, ex, wb);
        check("sll", ex_data_o, 32'd2);
        issue(32'h310, 32'h0, 4'd6, 32'h8000_0000, 32'd4, ex, wb);
        check("srl", ex_data_o, 32'h0800_0000);
        issue(32'h314, 32'h0, 4'd7, 32'h8000_0000, 32'd4, ex, wb);
        check("sra", ex_data_o, 32'hF800_0000);
        issue(32'h318, 32'h0, 4'd3, 32'hFFFF_FFFF, 32'd1, ex, wb);
        check("slt", ex_data_o, 32'd1);
        issue(32'h31C, 32'h0, 4'd4, 32'hFFFF_FFFF, 32'd1, ex, wb);
        check("sltu", ex_data_o, 32'd0);
        issue(32'h320, 32'h0, 4'd8, 32'hF0F0, 32'h0FF0, ex, wb);
        check("or", ex_data_o, 32'hFFF0);
        issue(32'h324, 32'h0, 4'd12, 32'd5, 32'd7, ex, wb);
        check("op12", ex_data_o, 32'h0);

        // Branch comparisons
        ex = '0; ex.branch_alu = 1'b1;
        issue(32'h328, 32'h0, 4'd1, 32'd9, 32'd9, ex, wb);
        check("beq_taken", 32'(branch_comp_flag_o), 32'h1);
        ex.zeroflag_inv = 1'b1;
        issue(32'h32C, 32'h0, 4'd1, 32'd9, 32'd9, ex, wb);
        check("bne_equal", 32'(branch_comp_flag_o), 32'h0);
        issue(32'h330, 32'h0, 4'd1, 32'd9, 32'd3, ex, wb);
        check("bne_diff", 32'(branch_comp_flag_o), 32'h1);
        ex = '0;
        issue(32'h334, 32'h0, 4'd1, 32'd9, 32'd9, ex, wb);
        check("no_branch", 32'(branch_comp_flag_o), 32'h0);

        // Stall for three cycles with inputs changing underneath
        issue(32'h400, 32'h0020_81B3, 4'd0, 32'd5, 32'd7, ex, wb);
        stall_ctrl = 1'b1;
        program_count_i = 32'h600; instruction_i = 32'hFFFF_FFFF;
        rdata1_i = 32'd100; rdata2_i = 32'd200; alu_op_ctrl_i = 4'd1;
        for (int i = 0; i < 3; i++) tick();
        check("stall_ex", ex_data_o, 32'd12);
        check("stall_store", store_data_o, 32'd7);
        check("stall_id_pc", id_pc_o, 32'h400);
        stall_ctrl = 1'b0;
        issue(32'h500, 32'h4020_81B3, 4'd1, 32'd30, 32'd8, ex, wb);
        check("post_stall", ex_data_o, 32'd22);

        // Stall outranks a pending bubble; the bubble lands once released
        issue(32'h700, 32'h0, 4'd5, 32'hF0F0, 32'h0FF0, ex, wb);
        check("xor", ex_data_o, 32'hFF00);
        no_op_flag_i = 1'b1;
        tick();
        stall_ctrl = 1'b1;
        tick();
        check("stall_bubble_ex", ex_data_o, 32'hFF00);
        check("stall_bubble_nop", 32'(id_no_op_flag_o), 32'h1);
        stall_ctrl = 1'b0;
        tick();
        check("bubble_ex", ex_data_o, 32'h0);
        check("bubble_store", store_data_o, 32'h0);
        check("bubble_wb", 32'(wb_ctrl_o), 32'h0);

        // Reset mid-stream overrides stall and flushes everything
        wb = '1;
        issue(32'h800, 32'h0020_81B3, 4'd0, 32'd5, 32'd7, ex, wb);
        check("pre_reset", ex_data_o, 32'd12);
        rst_n = 1'b0; stall_ctrl = 1'b1;
        tick();
        check("mid_rst_ex", ex_data_o, 32'h0);
        check("mid_rst_store", store_data_o, 32'h0);
        check("mid_rst_wb", 32'(wb_ctrl_o), 32'h0);
        check("mid_rst_nop", 32'(id_no_op_flag_o), 32'h1);
        check("mid_rst_id_pc", id_pc_o, 32'h0);
        rst_n = 1'b1; stall_ctrl = 1'b0;
        tick();
        check("after_rst_ex", ex_data_o, 32'h0);
        check("after_rst_store", store_data_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
